apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Sequenced APB4 master for the APB side of the AXI4-Lite bridge. Accepts one transfer at a time on a valid/ready command port, drives SETUP and ACCESS phases itself, decodes the address onto one of NSLV slave selects, captures read data only on a completed transfer, and aborts hung slaves with a timeout. Returns one response per command on a valid/ready response port.

## Interface
- DATAWIDTH, 32, data bus width; must be a multiple of 8
- ADDRWIDTH, 32, address width
- NSLV, 4, number of APB slaves (1..16)
- SEL_LSB, 12, LSB of the slave-index field in the address
- TIMEOUT, 255, ACCESS cycles allowed before abort; 0 disables
- pclk  in  1  clock
- presetn  in  1  reset; one clock, asynchronous, active-low
- req_valid / req_ready  in / out  1  command handshake
- req_write  in  1  1 = write
- req_addr  in  ADDRWIDTH  byte address
- req_wdata  in  DATAWIDTH  write data
- req_strb  in  DATAWIDTH/8  write strobes
- req_prot  in  3  protection
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_slverr  out  1  slave error, decode error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel  out  NSLV  one-hot slave select
- penable, pwrite  out  1  APB controls
- paddr  out  ADDRWIDTH; pwdata  out  DATAWIDTH; pstrb  out  DATAWIDTH/8; pprot  out  3
- pready, pslverr  in  NSLV  per-slave responses
- prdata  in  NSLV*DATAWIDTH  per-slave read data, slave i at [i*DATAWIDTH +: DATAWIDTH]

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid, latch command; idx = req_addr[SEL_LSB +: $clog2(NSLV)] (0 if NSLV = 1). idx < NSLV -> SETUP; idx >= NSLV -> RESP with rsp_slverr = 1, no APB activity.
- SETUP: psel[idx] = 1, penable = 0, paddr/pwrite/pwdata/pprot from latch; pstrb = req_strb for writes, 0 for reads. -> ACCESS.
- ACCESS: penable = 1, other outputs stable. pready[idx] = 1 -> capture prdata slice (reads only), pslverr[idx] -> RESP. Otherwise increment wait counter; counter == TIMEOUT (TIMEOUT > 0) -> RESP with rsp_slverr = 1, rsp_timeout = 1.
- RESP: psel = 0, penable = 0, rsp_valid = 1, response fields stable until rsp_ready; then -> IDLE.
- rprdata is updated only on completed read ACCESS; never follows prdata combinationally.
- Wait counter width $clog2(TIMEOUT+1); cleared on entering SETUP.

## Timing
- Reset values: state IDLE, psel 0, penable 0, paddr 0, pwdata 0, pwrite 0, pstrb 0, pprot 0, rsp_valid 0, rsp_rdata 0, rsp_slverr 0, rsp_timeout 0, counter 0. req_ready = (state == IDLE).
- Command accepted at edge N -> SETUP in N+1, ACCESS from N+2; pready sampled high at edge N+k (k>=2) -> rsp_valid from N+k+1. Zero-wait read: 3 cycles req-to-rsp.
- Decode error: rsp_valid at N+1.
- Earliest next accept: cycle after rsp handshake (one IDLE cycle between transfers).
- pready high on the same cycle counter hits TIMEOUT: pready wins, normal completion.
- pready/pslverr of non-selected slaves ignored.
- presetn low mid-transfer: all outputs return to reset values asynchronously; in-flight command dropped, no response.

## Structure
- apb_pkg: state enum, response struct (rdata, slverr, timeout), helper for slave-index width.
- Sub-module apb_addr_decode: address + NSLV/SEL_LSB -> one-hot select and decode-error flag; purely combinational.

## Test plan
- Write addr 0x0000_1004, data 0xDEAD_BEEF, strb 0xF, slave 1 pready immediate -> psel = 4'b0010 SETUP then ACCESS, pstrb 0xF, rsp_valid 3 cycles after accept, slverr 0.
- Read slave 2 with 3 wait states, prdata 0x1234_5678 only on ready cycle, garbage before -> rsp_rdata 0x1234_5678, pstrb 0 throughout.
- NSLV = 3, addr 0x0000_3000 -> no psel, rsp_valid next cycle, slverr 1, rdata 0.
- TIMEOUT = 4, slave never ready -> abort after 4 ACCESS cycles, slverr 1, timeout 1; TIMEOUT reached with pready same cycle -> normal response.
- rsp_ready held low 5 cycles -> response stable, req_ready 0; pslverr = 1 on completion -> rsp_slverr 1.
- presetn pulsed low during ACCESS -> psel/penable 0 immediately, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB master controller.
package apb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic slverr;
        logic timeout;
    } rsp_flags_t;

    // Width of the slave-index field; a single slave still needs one bit to hold index 0.
    function automatic int unsigned sel_width(input int unsigned nslv);
        return (nslv > 1) ? 32'($clog2(nslv)) : 32'd1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 0) ? 32'($clog2(timeout + 1)) : 32'd1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address-to-slave decode: one-hot select plus an out-of-range flag.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SEL_LSB   = 12
) (
    input  logic [ADDRWIDTH-1:0] addr,
    output logic [NSLV-1:0]      sel_c,
    output logic                 dec_err_c
);

    localparam int unsigned IW = sel_width(NSLV);

    logic [IW-1:0] idx;
    logic          unused_addr;

    // Only the index field matters; the rest of the address is deliberately ignored.
    assign unused_addr = ^addr;

    generate
        if (NSLV > 1) begin : g_multi
            assign idx = addr[SEL_LSB +: IW];
        end else begin : g_single
            assign idx = '0;
        end
    endgenerate

    always_comb begin
        dec_err_c = (32'(idx) >= NSLV);
        sel_c     = NSLV'(1) << idx;
        if (dec_err_c) begin
            sel_c = '0;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Sequenced APB4 master: one command at a time, SETUP/ACCESS sequencing,
// address decode onto NSLV selects, timeout abort, one response per command.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SEL_LSB   = 12,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRWIDTH-1:0]      req_addr,
    input  logic [DATAWIDTH-1:0]      req_wdata,
    input  logic [DATAWIDTH/8-1:0]    req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATAWIDTH-1:0]      rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [NSLV-1:0]           psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDRWIDTH-1:0]      paddr,
    output logic [DATAWIDTH-1:0]      pwdata,
    output logic [DATAWIDTH/8-1:0]    pstrb,
    output logic [2:0]                pprot,
    input  logic [NSLV-1:0]           pready,
    input  logic [NSLV-1:0]           pslverr,
    input  logic [NSLV*DATAWIDTH-1:0] prdata
);

    localparam int unsigned SW = DATAWIDTH / 8;
    localparam int unsigned CW = cnt_width(TIMEOUT);

    state_t                 state, state_n;
    logic [NSLV-1:0]        psel_n;
    logic                   penable_n, pwrite_n, rsp_valid_n;
    logic [ADDRWIDTH-1:0]   paddr_n;
    logic [DATAWIDTH-1:0]   pwdata_n, rsp_rdata_n;
    logic [SW-1:0]          pstrb_n;
    logic [2:0]             pprot_n;
    logic [CW-1:0]          cnt, cnt_n, cnt_inc_c;
    rsp_flags_t             rsp_flags, rsp_flags_n;

    logic [NSLV-1:0]        dec_sel_c;
    logic                   dec_err_c;
    logic                   sel_ready_c, sel_err_c, tmo_hit_c;
    logic [DATAWIDTH-1:0]   sel_rdata_c;

    apb_addr_decode #(
        .ADDRWIDTH (ADDRWIDTH),
        .NSLV      (NSLV),
        .SEL_LSB   (SEL_LSB)
    ) u_decode (
        .addr      (req_addr),
        .sel_c     (dec_sel_c),
        .dec_err_c (dec_err_c)
    );

    assign req_ready   = (state == S_IDLE);
    assign rsp_slverr  = rsp_flags.slverr;
    assign rsp_timeout = rsp_flags.timeout;
    assign cnt_inc_c   = cnt + CW'(1);
    assign tmo_hit_c   = (TIMEOUT != 0) && (cnt_inc_c == CW'(TIMEOUT));

    // Response mux keyed on the registered one-hot select; unselected slaves never leak through.
    always_comb begin
        sel_ready_c = 1'b0;
        sel_err_c   = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (psel[i]) begin
                sel_ready_c = pready[i];
                sel_err_c   = pslverr[i];
                sel_rdata_c = prdata[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= S_IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_flags <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pstrb     <= pstrb_n;
            pprot     <= pprot_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_flags <= rsp_flags_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        pstrb_n     = pstrb;
        pprot_n     = pprot;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_flags_n = rsp_flags;
        cnt_n       = cnt;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (dec_err_c) begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = '0;
                        rsp_flags_n = '{slverr: 1'b1, timeout: 1'b0};
                    end else begin
                        state_n  = S_SETUP;
                        psel_n   = dec_sel_c;
                        pwrite_n = req_write;
                        paddr_n  = req_addr;
                        pwdata_n = req_wdata;
                        pstrb_n  = req_write ? req_strb : '0;
                        pprot_n  = req_prot;
                        cnt_n    = '0;
                    end
                end
            end
            S_SETUP: begin
                state_n   = S_ACCESS;
                penable_n = 1'b1;
            end
            S_ACCESS: begin
                // Completion takes priority over a timeout expiring in the same cycle.
                if (sel_ready_c) begin
                    state_n     = S_RESP;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = (pwrite || sel_err_c) ? '0 : sel_rdata_c;
                    rsp_flags_n = '{slverr: sel_err_c, timeout: 1'b0};
                end else if (tmo_hit_c) begin
                    state_n     = S_RESP;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                    rsp_flags_n = '{slverr: 1'b1, timeout: 1'b1};
                    cnt_n       = cnt_inc_c;
                end else begin
                    cnt_n = cnt_inc_c;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed + randomized bench for apb_master_ctrl (3 slaves, TIMEOUT = 4),
// checked against a transaction-level latency/response model.
module tb_apb_master_ctrl;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned NS   = 3;
    localparam int unsigned TOUT = 4;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [NS-1:0] psel, pready, pslverr;
    logic          penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [NS*DW-1:0] prdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .NSLV      (NS),
        .SEL_LSB   (12),
        .TIMEOUT   (TOUT)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random noise on every slave; the selected one gets the scripted response when rdy.
    task automatic drive_slaves(input int sel, input bit rdy, input bit err, input logic [31:0] rd);
        pready  = 3'($urandom);
        pslverr = 3'($urandom);
        prdata  = {$urandom, $urandom, $urandom};
        if (sel >= 0) begin
            pready[sel] = rdy;
            if (rdy) begin
                pslverr[sel]          = err;
                prdata[sel*32 +: 32]  = rd;
            end
        end
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input bit err, input logic [31:0] rd, input int hold);
        int          idx, lat;
        bit          derr, tmo, exp_err;
        logic [31:0] exp_rdata;
        idx       = int'((addr >> 12) & 32'd3);
        derr      = (idx >= int'(NS));
        tmo       = !derr && (waits >= int'(TOUT));
        lat       = derr ? 1 : (tmo ? 2 + int'(TOUT) : 3 + waits);
        exp_err   = derr || tmo || err;
        exp_rdata = (wr || exp_err) ? 32'd0 : rd;

        @(negedge pclk);
        chk("req_ready_idle", 32'(req_ready), 1);
        chk("psel_idle", 32'(psel), 0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        drive_slaves(-1, 1'b0, 1'b0, 32'd0);

        for (int c = 1; c <= lat; c++) begin
            @(negedge pclk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_write = 1'($urandom);
                req_strb  = 4'($urandom);
                req_prot  = 3'($urandom);
            end
            if (c < lat) begin
                chk("rsp_valid_busy", 32'(rsp_valid), 0);
                chk("req_ready_busy", 32'(req_ready), 0);
                chk("psel", 32'(psel), 32'(1) << idx);
                chk("penable", 32'(penable), (c >= 2) ? 1 : 0);
                chk("paddr", paddr, addr);
                chk("pwrite", 32'(pwrite), 32'(wr));
                chk("pwdata", pwdata, wdata);
                chk("pstrb", 32'(pstrb), wr ? 32'(strb) : 0);
                chk("pprot", 32'(pprot), 32'(prot));
                drive_slaves(idx, (c >= 2) && (c - 1 == waits + 1), err, rd);
            end else begin
                drive_slaves(-1, 1'b0, 1'b0, 32'd0);
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_slverr", 32'(rsp_slverr), 32'(exp_err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
                chk("psel_resp", 32'(psel), 0);
                chk("penable_resp", 32'(penable), 0);
                rsp_ready = (hold == 0);
            end
        end

        for (int h = 1; h <= hold; h++) begin
            @(negedge pclk);
            chk("rsp_valid_hold", 32'(rsp_valid), 1);
            chk("rsp_rdata_hold", rsp_rdata, exp_rdata);
            chk("rsp_slverr_hold", 32'(rsp_slverr), 32'(exp_err));
            chk("rsp_timeout_hold", 32'(rsp_timeout), 32'(tmo));
            chk("req_ready_hold", 32'(req_ready), 0);
            if (h == hold) rsp_ready = 1'b1;
        end

        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("rsp_valid_done", 32'(rsp_valid), 0);
        chk("req_ready_done", 32'(req_ready), 1);
    endtask

    initial begin
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        pready    = '0;
        pslverr   = '0;
        prdata    = '0;

        #3;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_pstrb", 32'(pstrb), 0);
        chk("rst_pprot", 32'(pprot), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_slverr", 32'(rsp_slverr), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write to slave 1
        xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h0, 0);
        // Read slave 2, 3 wait states
        xfer(1'b0, 32'h0000_2000, 32'h0000_0000, 4'hF, 3'd0, 3, 1'b0, 32'h1234_5678, 0);
        // Decode error (index 3 with 3 slaves)
        xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h5555_AAAA, 0);
        // Hung slave -> timeout; exactly-at-limit pready -> normal completion
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd1, 100, 1'b0, 32'hCAFE_F00D, 0);
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd1, int'(TOUT) - 1, 1'b0, 32'hCAFE_F00D, 0);
        // Back-pressured response with slave error
        xfer(1'b1, 32'h0000_1008, 32'h0BAD_F00D, 4'h5, 3'd7, 1, 1'b1, 32'h0, 5);

        // Reset pulse during ACCESS drops the transfer
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h1111_2222;
        req_strb  = 4'hF;
        @(negedge pclk);
        req_valid = 1'b0;
        drive_slaves(0, 1'b0, 1'b0, 32'd0);
        @(negedge pclk);
        chk("pre_rst_penable", 32'(penable), 1);
        drive_slaves(0, 1'b0, 1'b0, 32'd0);
        #2 presetn = 1'b0;
        #1;
        chk("midrst_psel", 32'(psel), 0);
        chk("midrst_penable", 32'(penable), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_req_ready", 32'(req_ready), 1);
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
        end
        xfer(1'b0, 32'h0000_0044, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'h7777_8888, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 5)), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
